kbd_key_fifo: RTL and testbench

KBD_KEY_FIFO -- requirements
Module: kbd_key_fifo

---
 rtl/kbd_key_fifo_if.sv | 61 ++++++
 rtl/kbd_key_fifo.sv | 145 ++++++++++++++
 tb/tb_kbd_key_fifo.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_key_fifo_if.sv
// -----------------------------------------------------------------------------
// kbd_key_fifo_if
//
// Bundles the scanner-side inputs and the consumer-side read port of the
// keyboard key FIFO into a single interface.
//
//   kbd_byte     [7:0]          ASCII code from the scanner (valid while kbd_state=1)
//   kbd_state                   scanner key-held level (1 = key down)
//   rd_ready                    consumer accepts rd_data this cycle
//   clr_overflow                single-cycle clear of the sticky overflow flag
//   rd_valid                    FIFO non-empty, rd_data is valid
//   rd_data      [7:0]          oldest queued code (first-word-fall-through)
//   count        [DEPTH_LOG2:0] number of queued entries
//   overflow                    sticky: an event was dropped because the FIFO was full
//
// Read handshake: a word transfers on any cycle where rd_valid and rd_ready
// are both 1. rd_valid never depends on rd_ready. rd_data is held stable
// until the word is taken. rd_ready while rd_valid=0 has no effect.
//
// Modports:
//   slave  - the FIFO itself (drives rd_valid/rd_data/count/overflow)
//   master - the environment (scanner + consumer)
//
// DEPTH_LOG2 must match the DEPTH_LOG2 of the kbd_key_fifo instance.
// -----------------------------------------------------------------------------
interface kbd_key_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);

  logic [7:0]          kbd_byte;
  logic                kbd_state;
  logic                rd_ready;
  logic                clr_overflow;
  logic                rd_valid;
  logic [7:0]          rd_data;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  modport slave (
    input  kbd_byte,
    input  kbd_state,
    input  rd_ready,
    input  clr_overflow,
    output rd_valid,
    output rd_data,
    output count,
    output overflow
  );

  modport master (
    output kbd_byte,
    output kbd_state,
    output rd_ready,
    output clr_overflow,
    input  rd_valid,
    input  rd_data,
    input  count,
    input  overflow
  );

endinterface : kbd_key_fifo_if

// File: rtl/kbd_key_fifo.sv
// -----------------------------------------------------------------------------
// kbd_key_fifo
//
// Turns the level-style output of a keyboard scanner (code + key-held level)
// into discrete key events and queues them in a first-word-fall-through FIFO.
//
// A key event is a cycle with kbd_state=1 where either the key was not held
// on the previous cycle (press edge) or the code differs from the last
// accepted code (roll-over onto a new key while another is still held).
// Holding one key never produces repeats.
//
// Parameters:
//   DEPTH_LOG2     FIFO depth is 2**DEPTH_LOG2 entries
//   DROP_UNMAPPED  1 = silently discard events whose code is 8'h2A
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   asynchronous active-high reset
//   bus   kbd_key_fifo_if.slave (scanner inputs, read port, status)
// -----------------------------------------------------------------------------
module kbd_key_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter bit DROP_UNMAPPED = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  kbd_key_fifo_if.slave  bus
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [7:0]          UNMAPPED  = 8'h2A;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt_q;
  logic                  overflow_q;
  logic                  prev_state;
  logic [7:0]            last_byte;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic                  key_event;
  logic                  unmapped;
  logic                  event_ok;
  logic                  full;
  logic                  rd_valid_int;
  logic                  pop;
  logic                  push;
  logic                  ovf_set;
  logic [DEPTH_LOG2:0]   cnt_d;
  logic                  overflow_d;

  always_comb begin
    key_event    = 1'b0;
    unmapped     = 1'b0;
    event_ok     = 1'b0;
    full         = 1'b0;
    rd_valid_int = 1'b0;
    pop          = 1'b0;
    push         = 1'b0;
    ovf_set      = 1'b0;
    cnt_d        = cnt_q;
    overflow_d   = overflow_q;

    key_event = bus.kbd_state && (!prev_state || (bus.kbd_byte != last_byte));
    unmapped  = DROP_UNMAPPED && (bus.kbd_byte == UNMAPPED);
    event_ok  = key_event && !unmapped;

    full         = (cnt_q == DEPTH_CNT);
    rd_valid_int = (cnt_q != '0);
    pop          = rd_valid_int && bus.rd_ready;

    // When full, a simultaneous pop frees the slot the new event needs, so the
    // event is still stored and nothing is lost.
    push    = event_ok && (!full || pop);
    ovf_set = event_ok && full && !pop;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // Set takes priority over clear so a drop is never lost to a clear issued
    // in the same cycle.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      prev_state <= 1'b0;
      last_byte  <= 8'h00;
    end else begin
      prev_state <= bus.kbd_state;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      // last_byte follows every mapped event, including one dropped on full,
      // so a key held through an overflow does not keep re-triggering.
      if (event_ok) begin
        last_byte <= bus.kbd_byte;
      end
      // Pointers are DEPTH_LOG2 bits wide, so the increment wraps
      // depth-1 -> 0 on its own.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.kbd_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rd_valid = rd_valid_int;
  assign bus.rd_data  = mem[rd_ptr];
  assign bus.count    = cnt_q;
  assign bus.overflow = overflow_q;

endmodule : kbd_key_fifo

// File: tb/tb_kbd_key_fifo.sv
// -----------------------------------------------------------------------------
// tb_kbd_key_fifo
//
// Directed bench for kbd_key_fifo (DEPTH_LOG2=4, DROP_UNMAPPED=1).
// Inputs change 1 time unit after each rising edge; outputs are checked
// at that same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_kbd_key_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  kbd_key_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  kbd_key_fifo #(
    .DEPTH_LOG2    (DEPTH_LOG2),
    .DROP_UNMAPPED (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated press: key down for one cycle, then up for one cycle.
  task automatic press(input logic [7:0] code);
    bus.kbd_byte  = code;
    bus.kbd_state = 1'b1;
    tick();
    bus.kbd_state = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst              = 1'b1;
    bus.kbd_byte     = 8'h00;
    bus.kbd_state    = 1'b0;
    bus.rd_ready     = 1'b0;
    bus.clr_overflow = 1'b0;

    // Reset state
    #3;
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_count", 32'(bus.count), 32'd0);

    // Single press of 'A' held 5 cycles: exactly one entry
    bus.kbd_byte  = 8'h41;
    bus.kbd_state = 1'b1;
    tick();
    check("pressA_valid", 32'(bus.rd_valid), 32'd1);
    check("pressA_data",  32'(bus.rd_data),  32'h41);
    check("pressA_count", 32'(bus.count),    32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("holdA_count", 32'(bus.count),   32'd1);
    check("holdA_data",  32'(bus.rd_data), 32'h41);
    bus.kbd_state = 1'b0;
    tick();
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("popA_count", 32'(bus.count),    32'd0);
    check("popA_valid", 32'(bus.rd_valid), 32'd0);

    // Roll-over 'A' -> 'B' while held, then an unmapped press
    bus.kbd_byte  = 8'h41;
    bus.kbd_state = 1'b1;
    tick();
    bus.kbd_byte = 8'h42;
    tick();
    tick();
    check("roll_count", 32'(bus.count), 32'd2);
    bus.kbd_state = 1'b0;
    tick();
    bus.kbd_byte  = 8'h2A;
    bus.kbd_state = 1'b1;
    tick();
    tick();
    check("unmapped_count",    32'(bus.count),    32'd2);
    check("unmapped_overflow", 32'(bus.overflow), 32'd0);
    bus.kbd_state = 1'b0;
    tick();
    bus.rd_ready = 1'b1;
    check("roll_data0", 32'(bus.rd_data), 32'h41);
    tick();
    check("roll_data1", 32'(bus.rd_data), 32'h42);
    tick();
    check("roll_empty", 32'(bus.rd_valid), 32'd0);
    // rd_ready held while empty must not underflow
    tick();
    check("underflow_count", 32'(bus.count),    32'd0);
    check("underflow_valid", 32'(bus.rd_valid), 32'd0);
    bus.rd_ready = 1'b0;

    // Fill to depth with distinct codes
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = 8'h30 + 8'(i);
      press(exp_b);
      exp_q.push_back(exp_b);
    end
    check("full_count",    32'(bus.count),    32'd16);
    check("full_overflow", 32'(bus.overflow), 32'd0);

    // 17th press dropped; clear in the same cycle loses to set
    bus.kbd_byte     = 8'h5A;
    bus.kbd_state    = 1'b1;
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("drop_count",    32'(bus.count),    32'd16);
    check("drop_overflow", 32'(bus.overflow), 32'd1);
    bus.kbd_state = 1'b0;
    tick();
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("clr_overflow", 32'(bus.overflow), 32'd0);

    // Full with simultaneous press and pop: both take effect
    bus.kbd_byte  = 8'h5B;
    bus.kbd_state = 1'b1;
    bus.rd_ready  = 1'b1;
    tick();
    bus.kbd_state = 1'b0;
    bus.rd_ready  = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h5B);
    check("fullpp_count",    32'(bus.count),    32'd16);
    check("fullpp_overflow", 32'(bus.overflow), 32'd0);
    tick();

    // Drain in order
    bus.rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = exp_q.pop_front();
      check($sformatf("drain_data%0d", i), 32'(bus.rd_data), 32'(exp_b));
      tick();
    end
    bus.rd_ready = 1'b0;
    check("drain_empty", 32'(bus.rd_valid), 32'd0);
    check("drain_count", 32'(bus.count),    32'd0);

    // Wrap: 40 press/pop pairs
    for (int i = 0; i < 40; i++) begin
      exp_b         = 8'h80 + 8'(i);
      bus.kbd_byte  = exp_b;
      bus.kbd_state = 1'b1;
      tick();
      check($sformatf("wrap_data%0d", i),  32'(bus.rd_data), 32'(exp_b));
      check($sformatf("wrap_count%0d", i), 32'(bus.count),   32'd1);
      bus.kbd_state = 1'b0;
      bus.rd_ready  = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
      check($sformatf("wrap_pop%0d", i), 32'(bus.count), 32'd0);
    end

    // Async reset between edges with 5 entries queued
    for (int i = 0; i < 5; i++) press(8'h11 + 8'(i));
    check("pre_rst_count", 32'(bus.count), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count",    32'(bus.count),    32'd0);
    check("async_rst_valid",    32'(bus.rd_valid), 32'd0);
    check("async_rst_overflow", 32'(bus.overflow), 32'd0);
    bus.kbd_byte  = 8'h77;
    bus.kbd_state = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    check("rel_push_count", 32'(bus.count),   32'd1);
    check("rel_push_data",  32'(bus.rd_data), 32'h77);
    tick();
    tick();
    check("rel_hold_count", 32'(bus.count), 32'd1);
    bus.kbd_state = 1'b0;
    tick();

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_kbd_key_fifo
